// File: rtl/truth_table_extractor.sv
// truth_table_extractor: sweeps every input combination into a combinational
// DUT, holds each one SETTLE cycles, samples the DUT output and assembles the
// observed truth table, then flags whether it equals the expected table.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        sweep request, honoured only while idle
//   expected     expected table (bit k = output for combination k), latched at start
//   dut_in       combination currently driven to the DUT (bit 0 = in1)
//   dut_out      DUT output, sampled once per combination
//   busy         high while combinations are being driven
//   done         one-cycle pulse after the final sample
//   truth_table  observed table, bit k = dut_out sampled for combination k
//   match        truth_table == latched expected, valid from done until next start
module truth_table_extractor #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth_table,
    output logic                   match
);

    localparam int TT_W  = 1 << N_IN;
    localparam int IDX_W = N_IN + 1;

    // Terminal values for the settle counter and the combination index.
    localparam logic [3:0]       CNT_LAST = 4'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         cnt_q;
    logic [TT_W-1:0]    exp_q;
    logic [TT_W-1:0]    tt_q;
    logic               busy_q;
    logic               done_q;
    logic               match_q;

    logic               sample;
    logic               last;
    logic [TT_W-1:0]    tt_d;

    // A sample edge closes the settle window of the current combination.
    assign sample = (cnt_q == CNT_LAST);
    assign last   = (idx_q == IDX_LAST);

    // Table as it will look once the current combination is sampled; the
    // match flag is computed from this so it is valid in the done cycle.
    always_comb begin
        tt_d = tt_q;
        tt_d[idx_q[N_IN-1:0]] = dut_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_DRIVE;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        tt_q    <= '0;
                        match_q <= 1'b0;
                        exp_q   <= expected;
                        busy_q  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (sample) begin
                        tt_q  <= tt_d;
                        cnt_q <= '0;
                        if (last) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            match_q <= (tt_d == exp_q);
                            // Park the index so dut_in returns to 0.
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dut_in      = idx_q[N_IN-1:0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign match       = match_q;

endmodule
